spi_sram_bridge: RTL and testbench
==================================

SPI_SRAM_BRIDGE -- requirements
Module: spi_sram_bridge

Interface
REQ-001 SHALL have parameter SCK_DIV, default 2, meaning SCK half-period in clk cycles; legal range 1..15.
REQ-002 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port bus_address  input  16  CPU bus address.
REQ-005 SHALL have port bus_wdata  input  8  CPU write data.
REQ-006 SHALL have port bus_read  input  1  CPU read request; level, held until bus_done.
REQ-007 SHALL have port bus_write  input  1  CPU write request; level, held until bus_done.
REQ-008 SHALL have port bus_rdata  output  8  read data returned to the CPU.
REQ-009 SHALL have port bus_done  output  1  access complete; the CPU's bus_wait is !bus_done.
REQ-010 SHALL have port spi_cs_n  output  1  SRAM chip select, active low.
REQ-011 SHALL have port spi_sck  output  1  SPI clock, mode 0, idles low.
REQ-012 SHALL have port spi_mosi  output  1  serial data to the SRAM.
REQ-013 SHALL have port spi_miso  input  1  serial data from the SRAM.

Function
REQ-014 SHALL implement states IDLE, SHIFT, GAP and DONE.
REQ-015 IDLE: when bus_read or bus_write is high at edge T, SHALL latch address, wdata and type, then enter SHIFT.
- Read wins if both requests are high.
REQ-016 SHALL build a 32-bit frame, MSB first: command byte, address[15:8], address[7:0], data byte.
- Read: command 0x03, data byte 0x00.
- Write: command 0x02, data byte = latched wdata.
REQ-017 SHIFT, from T+1: spi_cs_n=0 and spi_mosi=frame bit 31.
- Each bit is spi_sck low for SCK_DIV cycles, then high for SCK_DIV cycles.
- spi_mosi changes only on the edge that drives spi_sck low, or at T+1 for bit 31.
REQ-018 SHALL sample spi_miso on the clk edge that drives spi_sck 0->1 and shift it into an 8-bit receive register.
REQ-019 SHALL use a 6-bit bit counter and a 4-bit divider counter.
- After the high phase of bit 0 (the 32nd bit): spi_sck=0, spi_cs_n=1, spi_mosi=0, enter GAP.
REQ-020 GAP SHALL hold spi_cs_n high for SCK_DIV cycles, then enter DONE.
REQ-021 On entry to DONE, bus_done=1.
- Read: bus_rdata = the last 8 bits sampled, i.e. data-byte bits 7..0.
- Write: bus_rdata keeps its previous value.
REQ-022 Latency: bus_done first high at T+1+64*SCK_DIV+SCK_DIV cycles, i.e. T+131 for SCK_DIV=2.
REQ-023 DONE SHALL hold bus_done=1 while bus_read or bus_write is high.
- The cycle after both are low: bus_done=0, return to IDLE.
- A new request is accepted no earlier than the following edge.
REQ-024 Requests that change or drop during SHIFT or GAP SHALL be ignored: the latched frame completes unchanged.
- If the request is already low at DONE entry, bus_done is high for exactly 1 cycle.
REQ-025 bus_rdata SHALL be stable outside DONE entry, and bus_done SHALL never be high outside DONE.
REQ-026 spi_sck SHALL be 0 whenever spi_cs_n=1; spi_cs_n SHALL never glitch within a frame.

Reset
REQ-027 When rst=1 at an edge, next state SHALL be: IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, bus_done=0, bus_rdata=0x00, counters 0.
REQ-028 Reset mid-frame SHALL abort it: cs_n high on the next edge, and no bus_done for the aborted access.
REQ-029 The first request after rst deasserts SHALL be accepted on the first edge with rst=0.

Verification
REQ-030 Read, SCK_DIV=2: bus_read=1, address 0x1234; SRAM model returns 0xA5.
- MOSI frame 0x03_12_34_00.
- bus_done at T+131; bus_rdata=0xA5.
REQ-031 Write: bus_write=1, address 0xBEEF, wdata 0x5A.
- MOSI frame 0x02_BE_EF_5A.
- bus_rdata unchanged; a following read of 0xBEEF returns 0x5A.
REQ-032 Hold and release: request held 10 cycles past DONE -> bus_done high 10+ cycles, low the cycle after release.
- Next request: cs_n low no earlier than 2 cycles after release.
REQ-033 Reset at bit 20 of a read -> cs_n=1, sck=0, bus_done=0, bus_rdata=0x00 on the next edge.
- A new read then completes normally.
REQ-034 SCK_DIV=1 with bus_read and bus_write both high -> read frame sent.
- bus_done at T+66; SCK period 2 clk cycles.
REQ-035 Request dropped at bit 5 -> frame completes, bus_done pulses exactly 1 cycle, returns to IDLE.

Source files
------------

// File: rtl/spi_sram_bridge_if.sv
// Purpose: CPU-side bus and SPI pin bundle for the SPI SRAM bridge.
// Latency: none, this is wiring only.
// Backpressure: the CPU holds bus_read/bus_write until bus_done.
interface spi_sram_bridge_if;
  logic [15:0] bus_address;
  logic [7:0]  bus_wdata;
  logic        bus_read;
  logic        bus_write;
  logic [7:0]  bus_rdata;
  logic        bus_done;
  logic        spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso;

  // Bridge side: receives CPU requests, drives the SPI pins.
  modport slave (
    input  bus_address, bus_wdata, bus_read, bus_write, spi_miso,
    output bus_rdata, bus_done, spi_cs_n, spi_sck, spi_mosi
  );

  // CPU plus SRAM side: issues requests, returns MISO.
  modport master (
    output bus_address, bus_wdata, bus_read, bus_write, spi_miso,
    input  bus_rdata, bus_done, spi_cs_n, spi_sck, spi_mosi
  );
endinterface

// File: rtl/spi_sram_bridge.sv
// Purpose: turns single-byte CPU reads/writes into 32-bit mode-0 SPI SRAM frames.
// Latency: bus_done rises 65*SCK_DIV edges after the request is accepted.
// Backpressure: bus_done stays high until the CPU drops its request; IDLE re-arms one edge later.
module spi_sram_bridge #(
  parameter int SCK_DIV = 2
) (
  input logic              clk,
  input logic              rst,
  spi_sram_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam logic [3:0] DIV_LAST = 4'(SCK_DIV - 1);

  state_t      state_q;
  logic [30:0] frame_q;    // frame bits still to be sent, next bit in [30]
  logic [7:0]  rx_q;
  logic [7:0]  rdata_q;
  logic [5:0]  bit_q;
  logic [3:0]  div_q;
  logic        is_read_q;
  logic        cs_n_q;
  logic        sck_q;
  logic        mosi_q;
  logic        done_q;
  logic [31:0] frame_d;

  // Frame for the request currently on the bus; a read wins over a write.
  always_comb begin
    frame_d = {8'h02, bus.bus_address, bus.bus_wdata};
    if (bus.bus_read) begin
      frame_d = {8'h03, bus.bus_address, 8'h00};
    end
  end

  // Bridge FSM: all SPI pins and bus outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      is_read_q <= 1'b0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.bus_read || bus.bus_write) begin
            frame_q   <= frame_d[30:0];
            mosi_q    <= frame_d[31];
            is_read_q <= bus.bus_read;
            cs_n_q    <= 1'b0;
            sck_q     <= 1'b0;
            div_q     <= '0;
            bit_q     <= 6'd31;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 4'd1;
          end else begin
            div_q <= '0;
            if (!sck_q) begin
              // Rising SCK: the SRAM's MISO has been stable for the whole low phase.
              sck_q <= 1'b1;
              rx_q  <= {rx_q[6:0], bus.spi_miso};
            end else begin
              sck_q <= 1'b0;
              if (bit_q == 6'd0) begin
                cs_n_q  <= 1'b1;
                mosi_q  <= 1'b0;
                state_q <= GAP;
              end else begin
                bit_q   <= bit_q - 6'd1;
                mosi_q  <= frame_q[30];
                frame_q <= {frame_q[29:0], 1'b0};
              end
            end
          end
        end
        GAP: begin
          // Chip-select recovery time before the access is reported done.
          if (div_q != DIV_LAST) begin
            div_q <= div_q + 4'd1;
          end else begin
            div_q   <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
            if (is_read_q) begin
              rdata_q <= rx_q;
            end
          end
        end
        DONE: begin
          if (!bus.bus_read && !bus.bus_write) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign bus.bus_done  = done_q;
  assign bus.spi_cs_n  = cs_n_q;
  assign bus.spi_sck   = sck_q;
  assign bus.spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Bench for spi_sram_bridge: one instance at SCK_DIV=2, one at SCK_DIV=1,
// each talking to a small behavioural SPI SRAM.
module tb_spi_sram_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   viol = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  spi_sram_bridge_if ifa();
  spi_sram_bridge_if ifb();

  spi_sram_bridge #(.SCK_DIV(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  spi_sram_bridge #(.SCK_DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Behavioural SPI SRAM, mode 0: samples MOSI on rising SCK, drives MISO after falling SCK.
  for (genvar g = 0; g < 2; g++) begin : gen_sram
    wire sck  = (g == 0) ? ifa.spi_sck  : ifb.spi_sck;
    wire csn  = (g == 0) ? ifa.spi_cs_n : ifb.spi_cs_n;
    wire mosi = (g == 0) ? ifa.spi_mosi : ifb.spi_mosi;
    logic        miso_r = 1'b0;
    logic [7:0]  mem [0:65535];
    logic [31:0] shreg = '0;
    logic [31:0] frame_cap = '0;
    logic [15:0] addr_l = '0;
    int          cnt = 0;

    initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h1234] = 8'hA5;
      mem[16'hBEEF] = 8'h11;
    end

    always @(negedge csn) cnt = 0;

    always @(posedge sck) begin
      if (!csn) begin
        shreg = {shreg[30:0], mosi};
        cnt = cnt + 1;
        if (cnt == 24) addr_l = shreg[15:0];
        if (cnt == 32) begin
          frame_cap = shreg;
          if (shreg[31:24] == 8'h02) mem[shreg[23:8]] = shreg[7:0];
        end
      end
    end

    always @(negedge sck) begin
      if (!csn && cnt >= 24 && cnt < 32) miso_r = mem[addr_l][3'(31 - cnt)];
    end
  end

  assign ifa.spi_miso = gen_sram[0].miso_r;
  assign ifb.spi_miso = gen_sram[1].miso_r;

  // Pin invariants: SCK only toggles inside a frame, done never overlaps a frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.spi_cs_n && ifa.spi_sck) viol++;
      if (ifb.spi_cs_n && ifb.spi_sck) viol++;
      if (!ifa.spi_cs_n && ifa.bus_done) viol++;
      if (!ifb.spi_cs_n && ifb.bus_done) viol++;
    end
  end

  // Scoreboard state
  logic [7:0]  ref_mem [int];
  logic [7:0]  exp_last_rd [2];
  logic [31:0] exp_frame_q [$];
  logic [7:0]  exp_rdata_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel != 0) ? ifb.bus_done : ifa.bus_done;
  endfunction
  function automatic logic get_csn(input int sel);
    return (sel != 0) ? ifb.spi_cs_n : ifa.spi_cs_n;
  endfunction
  function automatic logic get_sck(input int sel);
    return (sel != 0) ? ifb.spi_sck : ifa.spi_sck;
  endfunction
  function automatic logic get_mosi(input int sel);
    return (sel != 0) ? ifb.spi_mosi : ifa.spi_mosi;
  endfunction
  function automatic logic [7:0] get_rdata(input int sel);
    return (sel != 0) ? ifb.bus_rdata : ifa.bus_rdata;
  endfunction
  function automatic logic [31:0] get_frame(input int sel);
    return (sel != 0) ? gen_sram[1].frame_cap : gen_sram[0].frame_cap;
  endfunction

  task automatic drive(input int sel, input bit rd, input bit wr,
                       input logic [15:0] addr, input logic [7:0] wd);
    if (sel == 0) begin
      ifa.bus_read = rd; ifa.bus_write = wr; ifa.bus_address = addr; ifa.bus_wdata = wd;
    end else begin
      ifb.bus_read = rd; ifb.bus_write = wr; ifb.bus_address = addr; ifb.bus_wdata = wd;
    end
  endtask

  // Entered and left at a falling clk edge. hold: extra cycles the request stays
  // up after done; drop_at: cycle within the frame at which the request is dropped.
  task automatic run_access(input int sel, input bit rd, input bit wr,
                            input logic [15:0] addr, input logic [7:0] wd,
                            input int hold, input int drop_at, input int sckdiv);
    logic [31:0] ef;
    logic [7:0]  er;
    int t0, n, r1, r2;
    bit prev, sck_now;
    ef = rd ? {8'h03, addr, 8'h00} : {8'h02, addr, wd};
    er = rd ? ref_mem[int'(addr)] : exp_last_rd[sel];
    if (!rd) ref_mem[int'(addr)] = wd;
    exp_last_rd[sel] = er;
    exp_frame_q.push_back(ef);
    exp_rdata_q.push_back(er);
    drive(sel, rd, wr, addr, wd);
    t0 = cyc + 1;
    @(negedge clk);
    check("cs_low_at_T1", 32'(get_csn(sel)), 32'd0);
    check("mosi_bit31_at_T1", 32'(get_mosi(sel)), 32'(ef[31]));
    r1 = -1; r2 = -1; prev = 1'b0; n = 0;
    while (!get_done(sel) && n < 300) begin
      sck_now = get_sck(sel);
      if (sck_now && !prev) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      prev = sck_now;
      @(negedge clk);
      n++;
      if (drop_at > 0 && n == drop_at) drive(sel, 1'b0, 1'b0, addr, wd);
    end
    check("done_seen", 32'(get_done(sel)), 32'd1);
    check("done_latency", 32'(cyc - t0), 32'(64 * sckdiv + sckdiv));
    check("sck_period", 32'(r2 - r1), 32'(2 * sckdiv));
    check("mosi_frame", get_frame(sel), exp_frame_q.pop_front());
    check("rdata", 32'(get_rdata(sel)), 32'(exp_rdata_q.pop_front()));
    if (drop_at > 0) begin
      @(negedge clk);
      check("done_single_pulse", 32'(get_done(sel)), 32'd0);
    end else begin
      if (hold > 0) begin
        repeat (hold) @(negedge clk);
        check("done_held", 32'(get_done(sel)), 32'd1);
      end
      drive(sel, 1'b0, 1'b0, addr, wd);
      @(negedge clk);
      check("done_low_after_release", 32'(get_done(sel)), 32'd0);
      check("cs_high_after_release", 32'(get_csn(sel)), 32'd1);
    end
  endtask

  initial begin
    ref_mem[32'h1234] = 8'hA5;
    ref_mem[32'hBEEF] = 8'h11;
    exp_last_rd[0] = 8'h00;
    exp_last_rd[1] = 8'h00;
    drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    drive(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(ifa.spi_cs_n), 32'd1);
    check("rst_sck", 32'(ifa.spi_sck), 32'd0);
    check("rst_mosi", 32'(ifa.spi_mosi), 32'd0);
    check("rst_done", 32'(ifa.bus_done), 32'd0);
    check("rst_rdata", 32'(ifa.bus_rdata), 32'd0);
    rst = 1'b0;

    // Plain read, then write, then read-back held 10 cycles past done.
    run_access(0, 1'b1, 1'b0, 16'h1234, 8'h00, 0, 0, 2);
    run_access(0, 1'b0, 1'b1, 16'hBEEF, 8'h5A, 0, 0, 2);
    run_access(0, 1'b1, 1'b0, 16'hBEEF, 8'h00, 10, 0, 2);

    // Reset in the middle of a read frame (around bit 20).
    drive(0, 1'b1, 1'b0, 16'h1234, 8'h00);
    repeat (46) @(negedge clk);
    check("abort_in_frame", 32'(ifa.spi_cs_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", 32'(ifa.spi_cs_n), 32'd1);
    check("abort_sck", 32'(ifa.spi_sck), 32'd0);
    check("abort_done", 32'(ifa.bus_done), 32'd0);
    check("abort_rdata", 32'(ifa.bus_rdata), 32'd0);
    exp_last_rd[0] = 8'h00;
    exp_last_rd[1] = 8'h00;
    rst = 1'b0;
    run_access(0, 1'b1, 1'b0, 16'h1234, 8'h00, 0, 0, 2);

    // Request dropped early in the frame: frame completes, done pulses once.
    run_access(0, 1'b1, 1'b0, 16'hBEEF, 8'h00, 0, 22, 2);

    // SCK_DIV=1 with read and write both high: read frame goes out.
    run_access(1, 1'b1, 1'b1, 16'h1234, 8'hFF, 0, 0, 1);

    repeat (4) @(negedge clk);
    check("pin_invariants", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
